mem_arbiter: RTL

- Shares one single-port synchronous word RAM between the core's instruction-fetch port and its load/store port.
- Arbitrates round-robin and drives the RAM.
- Tracks the single outstanding read through a fixed-latency return path.
- Returns read data to the requester that issued it.
- Sits between the cpu core (fetch/data master ports) and the unified memory, letting the core share one memory.

---
 rtl/mem_arbiter.sv | 73 +++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of one single-port RAM between fetch and load/store ports,
// tracking the single outstanding read through a fixed-latency return path.
module mem_arbiter #(
    parameter int ADDR_WIDTH   = 10,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  if_req_i,
    input  logic [31:0]           if_addr_i,
    output logic                  if_gnt_o,
    output logic                  if_rvalid_o,
    output logic [31:0]           if_rdata_o,
    input  logic                  d_req_i,
    input  logic                  d_we_i,
    input  logic [11:0]           d_addr_i,
    input  logic [31:0]           d_wdata_i,
    output logic                  d_gnt_o,
    output logic                  d_rvalid_o,
    output logic [31:0]           d_rdata_o,
    output logic                  mem_en_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [31:0]           mem_wdata_o,
    input  logic [31:0]           mem_rdata_i
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t      state, state_n;
    logic [2:0]  cnt, cnt_n;
    logic        owner, owner_n, last, last_n;
    logic        ret, opp, pick_d, rd_gnt;
    logic [31:0] d_addr_ext;
    logic        unused_bits;

    assign d_addr_ext  = {20'b0, d_addr_i};
    assign unused_bits = ^{if_addr_i, d_addr_ext};

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state <= IDLE;
            cnt   <= '0;
            owner <= 1'b0;
            last  <= 1'b1;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            owner <= owner_n;
            last  <= last_n;
        end
    end

    // owner/last: 1 = data port, 0 = fetch port; grants are masked while reset is held
    always_comb begin
        ret         = state == BUSY && cnt == 3'd1;
        opp         = rstn_i && (state == IDLE || ret);
        pick_d      = d_req_i && (!if_req_i || !last);
        if_gnt_o    = opp && if_req_i && !pick_d;
        d_gnt_o     = opp && pick_d;
        mem_en_o    = if_gnt_o || d_gnt_o;
        mem_we_o    = d_gnt_o && d_we_i;
        mem_addr_o  = d_gnt_o ? d_addr_ext[ADDR_WIDTH+1:2] : if_gnt_o ? if_addr_i[ADDR_WIDTH+1:2] : '0;
        mem_wdata_o = mem_we_o ? d_wdata_i : '0;
        if_rvalid_o = ret && !owner;
        d_rvalid_o  = ret && owner;
        if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
        d_rdata_o   = d_rvalid_o ? mem_rdata_i : '0;
        rd_gnt      = if_gnt_o || (d_gnt_o && !d_we_i);
        state_n     = rd_gnt ? BUSY : ret ? IDLE : state;
        cnt_n       = rd_gnt ? 3'(READ_LATENCY) : state == BUSY ? cnt - 3'd1 : cnt;
        owner_n     = rd_gnt ? d_gnt_o : owner;
        last_n      = mem_en_o ? d_gnt_o : last;
    end
endmodule
